// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: decodes SCL edges, START/STOP and repeated START from the
// filtered lines, assembles address/data bytes with their ACK bit, and times out a stalled bus.
module i2c_bus_monitor #(
  parameter int TIMEOUT_CYCLES = 15625
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_f,
  input  logic       sda_f,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       rstart_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_addr,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic       timeout
);

  localparam int            CW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic rise;
    logic fall;
    logic start;
    logic stop;
  } bus_ev_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  logic          scl_prev, sda_prev;
  bus_ev_t       ev;
  logic          any_ev, to_hit;
  logic [CW-1:0] to_cnt;
  state_t        state_q, state_d;
  logic          take_bit, byte_done, take_ack;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          addr_flag;

  // A simultaneous SCL/SDA change fails the scl_prev & scl_f term, so it
  // only ever shows up as an SCL edge.
  always_comb begin
    ev.rise  = ~scl_prev &  scl_f;
    ev.fall  =  scl_prev & ~scl_f;
    ev.start =  scl_prev &  scl_f &  sda_prev & ~sda_f;
    ev.stop  =  scl_prev &  scl_f & ~sda_prev &  sda_f;
  end

  assign any_ev = |ev;
  assign to_hit = bus_busy & ~any_ev & (to_cnt == TO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      timeout    <= 1'b0;
      bus_busy   <= 1'b0;
    end else begin
      scl_prev   <= scl_f;
      sda_prev   <= sda_f;
      scl_rise   <= ev.rise;
      scl_fall   <= ev.fall;
      start_det  <= ev.start & ~bus_busy;
      rstart_det <= ev.start &  bus_busy;
      stop_det   <= ev.stop;
      timeout    <= to_hit;
      if (ev.start)               bus_busy <= 1'b1;
      else if (ev.stop || to_hit) bus_busy <= 1'b0;
    end
  end

  // Stall counter: idles at zero, restarts on any bus activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          to_cnt <= '0;
    else if (!bus_busy || any_ev || to_hit) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ev.start)               state_d = S_DATA;
    else if (ev.stop || to_hit) state_d = S_IDLE;
    else begin
      case (state_q)
        S_DATA:  if (ev.rise && bit_cnt == 3'd7) state_d = S_ACK;
        S_ACK:   if (ev.rise)                    state_d = S_DATA;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    take_bit  = 1'b0;
    byte_done = 1'b0;
    take_ack  = 1'b0;
    case (state_q)
      S_DATA: begin
        take_bit  = ev.rise;
        byte_done = ev.rise & (bit_cnt == 3'd7);
      end
      S_ACK:   take_ack = ev.rise;
      default: ;
    endcase
  end

  // Only seven bits are stored; the eighth goes straight into byte_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      addr_flag    <= 1'b0;
      byte_data    <= '0;
      byte_is_addr <= 1'b0;
      byte_valid   <= 1'b0;
      ack_valid    <= 1'b0;
      ack_bit      <= 1'b0;
    end else begin
      byte_valid <= byte_done;
      ack_valid  <= take_ack;
      if (ev.start) begin
        shreg     <= '0;
        bit_cnt   <= '0;
        addr_flag <= 1'b1;
      end else if (ev.stop || to_hit) begin
        bit_cnt   <= '0;
      end else if (take_bit) begin
        shreg   <= {shreg[5:0], sda_f};
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          byte_data    <= {shreg, sda_f};
          byte_is_addr <= addr_flag;
        end
      end else if (take_ack) begin
        ack_bit   <= sda_f;
        addr_flag <= 1'b0;
        bit_cnt   <= '0;
      end
    end
  end

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Consumes the glitch-filtered SCL and SDA levels from the two input filter instances; produces bus-condition events and assembled bytes for the controller FSM.
- Detects START, repeated START and STOP; tracks bus busy; emits SCL edge strobes; shifts in 8-bit bytes plus the ACK bit.
- Times out a bus that is busy but has stalled.
- Purely an observer: never drives the bus.

Parameters:
- TIMEOUT_CYCLES, 15625, clk cycles with no SCL edge while busy before the bus is declared stalled (100 us at 156.25 MHz); minimum 2.

Ports:
- clk  input  1  system clock, 156.25 MHz
- rst_n  input  1  asynchronous active-low reset
- scl_f  input  1  filtered SCL level
- sda_f  input  1  filtered SDA level
- scl_rise  output  1  one-cycle strobe, SCL 0->1
- scl_fall  output  1  one-cycle strobe, SCL 1->0
- start_det  output  1  one-cycle strobe, START while bus not busy
- rstart_det  output  1  one-cycle strobe, START while bus busy (repeated START)
- stop_det  output  1  one-cycle strobe, STOP
- bus_busy  output  1  level; high from START until STOP or timeout
- byte_valid  output  1  one-cycle strobe, byte_data updated
- byte_data  output  8  last completed byte, MSB first on the wire
- byte_is_addr  output  1  valid with byte_valid; high for the first byte after a START or repeated START
- ack_valid  output  1  one-cycle strobe, ack_bit updated
- ack_bit  output  1  SDA sampled on the 9th SCL rise (0 = ACK, 1 = NACK)
- timeout  output  1  one-cycle strobe, stall detected

Behaviour:
- Reset: all outputs 0. scl_prev/sda_prev registers reset to 1 (idle bus), so no false event is generated on reset release. FSM goes to IDLE; counters clear.
- Edge decode uses the current input and the prev register. Every event output is registered. A strobe is high for exactly the cycle following edge k, where edge k is the first clk edge that samples the new level.
- scl_rise = !scl_prev & scl_f; scl_fall = scl_prev & !scl_f.
- START = scl_prev & scl_f & sda_prev & !sda_f.
- STOP = scl_prev & scl_f & !sda_prev & sda_f.
- If SCL and SDA change in the same cycle: only the SCL edge is reported. No START or STOP is generated.
- START with bus_busy=0: start_det=1. START with bus_busy=1: rstart_det=1. bus_busy is set at the same edge as the strobe.
- STOP: stop_det=1 and bus_busy=0 at the same edge. STOP while not busy still pulses stop_det.
- FSM states:
  - IDLE: ignore SCL edges. START goes to DATA, bit_cnt=0, addr_flag=1.
  - DATA: on scl_rise, shift sda_f into the shift register and increment bit_cnt. When the 8th bit is taken, byte_data <= shifted byte, byte_valid=1, byte_is_addr=addr_flag, then go to ACK.
  - ACK: on the next scl_rise, ack_bit <= sda_f and ack_valid=1. Then addr_flag=0, bit_cnt=0, return to DATA.
- From any state:
  - STOP -> IDLE.
  - Repeated START -> DATA with bit_cnt=0 and addr_flag=1; a partial byte is discarded and no byte_valid is issued.
- byte_data and ack_bit hold their values until the next update.
- Timeout counter:
  - Runs only while bus_busy=1; cleared on any SCL edge, START or STOP.
  - When it reaches TIMEOUT_CYCLES-1: timeout=1, bus_busy=0, FSM -> IDLE, counter clears.
  - Saturates; never wraps while idle.
- START/STOP and an SCL edge cannot both be valid in the same cycle by construction. A START takes priority over the timeout expiring in the same cycle; the counter clears.
- rst_n asserted mid-byte: immediate return to reset values. No strobes on release.

Test Plan:
- Idle bus (scl_f=sda_f=1), release rst_n -> no strobes for 20 cycles; bus_busy=0.
- START, then address 0xA4 (8 SCL pulses, 10-cycle half-periods), SDA=0 on the 9th pulse, then STOP -> start_det once; byte_valid once with byte_data=0xA4 and byte_is_addr=1; ack_valid with ack_bit=0; stop_det once; bus_busy 1 only between START and STOP.
- START, 0x90 with ACK, 3 bits of data, repeated START, 0x91 with NACK -> rstart_det once; no byte_valid for the partial byte; second byte 0x91 with byte_is_addr=1 and ack_bit=1.
- START, 0x3C with ACK, 0x5A with ACK -> the second byte_valid has byte_data=0x5A and byte_is_addr=0.
- SCL and SDA toggled in the same cycle while SCL high -> scl_fall only; no start_det or stop_det.
- TIMEOUT_CYCLES=50: START, then SCL held for 60 cycles -> timeout exactly 50 cycles after the last event, bus_busy drops; a following START gives start_det (not rstart_det).
